// File: rtl/cache_axi_refill.sv
// cache_axi_refill
//
// Handles line misses for the cache. It sits between the I/D cache
// tag/data pair and the AXI crossbar, and acts as the AXI4 master.
// On a miss it first writes back the 16-word victim line as an INCR
// burst, if that line is dirty. It then fetches the missing 16-word line
// as an INCR burst. Finally it pulses `refresh` for one cycle so the tag
// and data arrays install the line.
//
// Ports
//   clk, rst           sole clock; synchronous active-high reset
//   flush              pipeline flush, suppresses install of the in-flight line
//   miss, write_back   miss request and "victim is dirty" qualifier
//   axi_raddr          line-aligned refill address
//   axi_waddr          line-aligned victim address
//   wb_line            victim line, word i at [32i+31:32i]
//   refresh            one-cycle install pulse
//   refill_line        fetched line, valid while refresh is high
//   busy               high whenever the FSM is not idle
//   ar*/r*             AXI read address and read data channels
//   aw*/w*/b*          AXI write address, write data and write response channels
module cache_axi_refill (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         miss,
    input  logic         write_back,
    input  logic [31:0]  axi_raddr,
    input  logic [31:0]  axi_waddr,
    input  logic [511:0] wb_line,
    output logic         refresh,
    output logic [511:0] refill_line,
    output logic         busy,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [2:0] {
        IDLE,
        WB_AW,
        WB_W,
        WB_B,
        RD_AR,
        RD_R,
        INSTALL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic          kill;
    logic [31:0]   raddr_q;
    logic [31:0]   waddr_q;
    logic [511:0]  victim_q;

    // Response codes are deliberately not acted upon; this fold only
    // marks them as intentionally consumed.
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};

    // Every burst is a full 16-beat line of 32-bit words.
    assign arlen   = 8'd15;
    assign awlen   = 8'd15;
    assign arsize  = 3'd2;
    assign awsize  = 3'd2;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;

    // The address and data outputs come straight from the registers
    // latched at miss time. So they stay stable through any stall, and
    // they read zero after reset.
    assign araddr = raddr_q;
    assign awaddr = waddr_q;
    assign wdata  = victim_q[{cnt, 5'd0} +: 32];
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            kill        <= 1'b0;
            raddr_q     <= 32'd0;
            waddr_q     <= 32'd0;
            victim_q    <= 512'd0;
            refill_line <= 512'd0;
        end else begin
            state <= state_next;

            // A request is captured only in IDLE. A flush after that point
            // leaves the bursts running; it only blocks the install.
            if (state == IDLE) begin
                if (miss) begin
                    raddr_q  <= axi_raddr;
                    waddr_q  <= axi_waddr;
                    victim_q <= wb_line;
                    kill     <= 1'b0;
                    cnt      <= 4'd0;
                end
            end else if (flush) begin
                kill <= 1'b1;
            end

            // The beat counter wraps from 15 to 0 on the last W beat. That
            // leaves it cleared for the refill burst that follows.
            if (state == WB_W && wready) begin
                cnt <= cnt + 4'd1;
            end

            if (state == RD_R && rvalid) begin
                refill_line[{cnt, 5'd0} +: 32] <= rdata;
                cnt <= (rlast || cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
            end
        end
    end

    // Next state and the Moore-style channel controls. No valid output
    // depends on its matching ready input.
    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        refresh    = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    state_next = write_back ? WB_AW : RD_AR;
                end
            end
            WB_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_next = WB_W;
                end
            end
            WB_W: begin
                wvalid = 1'b1;
                wlast  = (cnt == 4'd15);
                if (wready && cnt == 4'd15) begin
                    state_next = WB_B;
                end
            end
            WB_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid && (rlast || cnt == 4'd15)) begin
                    state_next = INSTALL;
                end
            end
            INSTALL: begin
                refresh    = ~kill;
                state_next = DONE;
            end
            DONE: begin
                // Dead cycle so the tag update settles before a new miss.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_axi_refill.sv
// tb_cache_axi_refill
//
// Bench for cache_axi_refill. An AXI slave process drives all the slave
// inputs. A monitor process records the handshakes. The main process runs
// a table of miss transactions, then hand-written sequences for
// miss-to-refresh timing, back-to-back misses, flush and mid-burst reset.
//
// Per-cycle order, all away from the rising edge: at the falling edge the
// main process drives the DUT inputs. At +1 the slave updates its ready
// and valid signals. At +2 the monitor logs the handshakes that the next
// rising edge will complete. At +3 the main process reads the results.
module tb_cache_axi_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         miss;
    logic         write_back;
    logic [31:0]  axi_raddr;
    logic [31:0]  axi_waddr;
    logic [511:0] wb_line;
    logic         refresh;
    logic [511:0] refill_line;
    logic         busy;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    cache_axi_refill dut (
        .clk(clk), .rst(rst), .flush(flush), .miss(miss), .write_back(write_back),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .wb_line(wb_line),
        .refresh(refresh), .refill_line(refill_line), .busy(busy),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] rbase;
        logic [31:0] wseed;
        int          ar_stall;
        int          aw_stall;
        int          w_stall;
        logic        r_toggle;
        int          exp_ar;
        int          exp_aw;
        int          exp_w;
        int          exp_r;
        int          exp_refresh;
        logic [31:0] exp_araddr;
        logic [31:0] exp_awaddr;
    } vec_t;

    // Slave configuration; only the main process writes these.
    int          cfg_ar_stall = 0;
    int          cfg_aw_stall = 0;
    int          cfg_w_stall  = 0;
    logic        cfg_toggle   = 1'b0;
    logic [31:0] cfg_rbase    = 32'd0;
    logic [31:0] cfg_wseed    = 32'd0;
    int          clear_gen    = 0;

    // Monitor records; only the monitor process writes these.
    int           seen_gen = 0;
    int           ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt, refresh_cnt;
    int           w_idx, w_bad, const_bad, order_bad, stable_bad;
    logic [31:0]  ar_addr_seen, aw_addr_seen;
    logic [511:0] snap_line;
    logic         prev_ar_stall, prev_aw_stall, prev_w_stall;
    logic [31:0]  prev_araddr, prev_awaddr, prev_wdata;
    logic         prev_wlast;

    // Slave-internal state.
    int   ar_wait, aw_wait, w_wait, r_idx, sw_idx;
    logic r_active, r_gap, b_pend;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;

    int checks = 0;
    int errors = 0;

    // AXI slave. It applies the handshakes completed at the last rising
    // edge, then drives the ready and valid signals for the next edge.
    initial begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0;
        rdata = 0; rresp = 0; bvalid = 0; bresp = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_idx = 0; sw_idx = 0;
        r_active = 0; r_gap = 0; b_pend = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0;
                bvalid = 0; rdata = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; r_idx = 0; sw_idx = 0;
                r_active = 0; r_gap = 0; b_pend = 0;
                ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
            end else begin
                if (ar_hs) begin
                    r_active = 1; r_idx = 0; r_gap = 0;
                end else if (r_hs) begin
                    r_idx = r_idx + 1;
                    if (r_idx == 16) r_active = 0;
                    r_gap = cfg_toggle;
                end else begin
                    r_gap = 0;
                end
                if (aw_hs) begin
                    sw_idx = 0; w_wait = 0;
                end
                if (w_hs) begin
                    sw_idx = sw_idx + 1;
                    if (sw_idx == 16) b_pend = 1;
                end
                if (b_hs) b_pend = 0;

                arready = arvalid && (ar_wait >= cfg_ar_stall);
                ar_wait = arvalid ? ar_wait + 1 : 0;
                awready = awvalid && (aw_wait >= cfg_aw_stall);
                aw_wait = awvalid ? aw_wait + 1 : 0;
                wready  = wvalid && (w_wait >= cfg_w_stall);
                if (wvalid) w_wait = w_wait + 1;
                rvalid = r_active && !r_gap;
                rdata  = cfg_rbase + 32'(r_idx);
                rlast  = (r_idx == 15);
                bvalid = b_pend;

                ar_hs = arvalid && arready;
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                r_hs  = rvalid && rready;
                b_hs  = bvalid && bready;
            end
        end
    end

    // Monitor: counts the handshakes that the next rising edge will
    // complete, checks each write beat, and checks that a stalled channel
    // holds its valid, address and data.
    initial begin
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; refresh_cnt = 0;
        w_idx = 0; w_bad = 0; const_bad = 0; order_bad = 0; stable_bad = 0;
        ar_addr_seen = 0; aw_addr_seen = 0; snap_line = 0;
        prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
        prev_araddr = 0; prev_awaddr = 0; prev_wdata = 0; prev_wlast = 0;
        forever begin
            @(negedge clk);
            #2;
            if (clear_gen != seen_gen) begin
                seen_gen = clear_gen;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
                refresh_cnt = 0; w_bad = 0; const_bad = 0; order_bad = 0;
                stable_bad = 0; ar_addr_seen = 0; aw_addr_seen = 0;
            end
            if (rst) begin
                prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                if (prev_ar_stall && !(arvalid && araddr == prev_araddr)) stable_bad++;
                if (prev_aw_stall && !(awvalid && awaddr == prev_awaddr)) stable_bad++;
                if (prev_w_stall && !(wvalid && wdata == prev_wdata && wlast == prev_wlast)) stable_bad++;
                if (arvalid && arready) begin
                    ar_cnt++;
                    ar_addr_seen = araddr;
                    if (arlen != 8'd15 || arsize != 3'd2 || arburst != 2'b01) const_bad++;
                    if (b_cnt < aw_cnt) order_bad++;
                end
                if (awvalid && awready) begin
                    aw_cnt++;
                    aw_addr_seen = awaddr;
                    w_idx = 0;
                    if (awlen != 8'd15 || awsize != 3'd2 || awburst != 2'b01) const_bad++;
                end
                if (wvalid && wready) begin
                    if (wdata !== cfg_wseed + 32'(w_idx) || wlast !== (w_idx == 15) || wstrb !== 4'hF)
                        w_bad++;
                    w_idx++;
                    w_cnt++;
                end
                if (bvalid && bready) b_cnt++;
                if (rvalid && rready) r_cnt++;
                if (refresh) begin
                    refresh_cnt++;
                    snap_line = refill_line;
                end
                prev_ar_stall = arvalid && !arready;
                prev_aw_stall = awvalid && !awready;
                prev_w_stall  = wvalid && !wready;
                prev_araddr = araddr;
                prev_awaddr = awaddr;
                prev_wdata  = wdata;
                prev_wlast  = wlast;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_arvalid"}, 512'(arvalid), 512'(0));
        checkOutput({tag, "_awvalid"}, 512'(awvalid), 512'(0));
        checkOutput({tag, "_wvalid"}, 512'(wvalid), 512'(0));
        checkOutput({tag, "_rready"}, 512'(rready), 512'(0));
        checkOutput({tag, "_bready"}, 512'(bready), 512'(0));
        checkOutput({tag, "_refresh"}, 512'(refresh), 512'(0));
        checkOutput({tag, "_busy"}, 512'(busy), 512'(0));
        checkOutput({tag, "_wlast"}, 512'(wlast), 512'(0));
        checkOutput({tag, "_araddr"}, 512'(araddr), 512'(0));
        checkOutput({tag, "_awaddr"}, 512'(awaddr), 512'(0));
        checkOutput({tag, "_wdata"}, 512'(wdata), 512'(0));
        checkOutput({tag, "_refill_line"}, refill_line, 512'(0));
    endtask

    // Configures the slave, clears the monitor and issues a one-cycle miss.
    task automatic applyStimulus(input vec_t v);
        cfg_ar_stall = v.ar_stall;
        cfg_aw_stall = v.aw_stall;
        cfg_w_stall  = v.w_stall;
        cfg_toggle   = v.r_toggle;
        cfg_rbase    = v.rbase;
        cfg_wseed    = v.wseed;
        clear_gen++;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wb_line[i*32 +: 32] = v.wseed + 32'(i);
        write_back = v.wb;
        axi_raddr  = v.raddr;
        axi_waddr  = v.waddr;
        miss       = 1'b1;
        @(negedge clk);
        miss = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #3;
            if (!busy) done = 1'b1;
        end
        checkOutput({name, "_idle_reached"}, 512'(done), 512'(1));
    endtask

    function automatic logic [511:0] makeLine(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    vec_t vecs[4];
    vec_t v;
    int   ref_cyc;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{wb: 1'b0, raddr: 32'h1FC0_0040, waddr: 32'hDEAD_0000, rbase: 32'hA000_0000,
                    wseed: 32'h0, ar_stall: 0, aw_stall: 0, w_stall: 0, r_toggle: 1'b0,
                    exp_ar: 1, exp_aw: 0, exp_w: 0, exp_r: 16, exp_refresh: 1,
                    exp_araddr: 32'h1FC0_0040, exp_awaddr: 32'h0};
        vecs[1] = '{wb: 1'b1, raddr: 32'h0000_2000, waddr: 32'h0000_1380, rbase: 32'hB000_0000,
                    wseed: 32'h0, ar_stall: 0, aw_stall: 0, w_stall: 0, r_toggle: 1'b0,
                    exp_ar: 1, exp_aw: 1, exp_w: 16, exp_r: 16, exp_refresh: 1,
                    exp_araddr: 32'h0000_2000, exp_awaddr: 32'h0000_1380};
        vecs[2] = '{wb: 1'b1, raddr: 32'h0000_8880, waddr: 32'h0000_4440, rbase: 32'hC000_0000,
                    wseed: 32'h5555_0000, ar_stall: 3, aw_stall: 3, w_stall: 3, r_toggle: 1'b1,
                    exp_ar: 1, exp_aw: 1, exp_w: 16, exp_r: 16, exp_refresh: 1,
                    exp_araddr: 32'h0000_8880, exp_awaddr: 32'h0000_4440};
        vecs[3] = '{wb: 1'b0, raddr: 32'hFFFF_FFC0, waddr: 32'h0, rbase: 32'h0000_0000,
                    wseed: 32'h0, ar_stall: 0, aw_stall: 0, w_stall: 0, r_toggle: 1'b1,
                    exp_ar: 1, exp_aw: 0, exp_w: 0, exp_r: 16, exp_refresh: 1,
                    exp_araddr: 32'hFFFF_FFC0, exp_awaddr: 32'h0};

        rst = 1'b1; flush = 1'b0; miss = 1'b0; write_back = 1'b0;
        axi_raddr = 32'd0; axi_waddr = 32'd0; wb_line = 512'd0;
        @(negedge clk);
        @(negedge clk);
        #3;
        checkResetOutputs("reset");
        checkOutput("const_ar", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'b01});
        checkOutput("const_aw", {awlen, awsize, awburst}, {8'd15, 3'd2, 2'b01});
        checkOutput("const_wstrb", 512'(wstrb), 512'(4'hF));
        @(negedge clk);
        rst = 1'b0;

        // Table of complete miss transactions.
        for (int n = 0; n < 4; n++) begin
            v = vecs[n];
            applyStimulus(v);
            waitIdle($sformatf("v%0d", n), 400);
            checkOutput($sformatf("v%0d_ar_count", n), 512'(ar_cnt), 512'(v.exp_ar));
            checkOutput($sformatf("v%0d_araddr", n), 512'(ar_addr_seen), 512'(v.exp_araddr));
            checkOutput($sformatf("v%0d_aw_count", n), 512'(aw_cnt), 512'(v.exp_aw));
            checkOutput($sformatf("v%0d_awaddr", n), 512'(aw_addr_seen), 512'(v.exp_awaddr));
            checkOutput($sformatf("v%0d_w_beats", n), 512'(w_cnt), 512'(v.exp_w));
            checkOutput($sformatf("v%0d_w_bad", n), 512'(w_bad), 512'(0));
            checkOutput($sformatf("v%0d_r_beats", n), 512'(r_cnt), 512'(v.exp_r));
            checkOutput($sformatf("v%0d_refresh", n), 512'(refresh_cnt), 512'(v.exp_refresh));
            checkOutput($sformatf("v%0d_order", n), 512'(order_bad), 512'(0));
            checkOutput($sformatf("v%0d_stable", n), 512'(stable_bad), 512'(0));
            checkOutput($sformatf("v%0d_const", n), 512'(const_bad), 512'(0));
            checkOutput($sformatf("v%0d_line", n), snap_line, makeLine(v.rbase));
            @(negedge clk);
            #3;
            checkOutput($sformatf("v%0d_line_hold", n), refill_line, makeLine(v.rbase));
        end

        // Miss-to-refresh timing with miss held high through DONE. The
        // refill address changes mid-burst, and the second request must
        // pick up the new value.
        cfg_ar_stall = 0; cfg_aw_stall = 0; cfg_w_stall = 0; cfg_toggle = 1'b0;
        cfg_rbase = 32'h7000_0000;
        clear_gen++;
        ref_cyc = -1;
        @(negedge clk);
        write_back = 1'b0; axi_raddr = 32'h0000_0A00; miss = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            #3;
            if (k == 5) axi_raddr = 32'h0000_0B40;
            if (refresh && ref_cyc < 0) ref_cyc = k;
            if (k == 1) begin
                checkOutput("t_c1_arvalid", 512'(arvalid), 512'(1));
                checkOutput("t_c1_araddr", 512'(araddr), 512'(32'h0000_0A00));
                checkOutput("t_c1_busy", 512'(busy), 512'(1));
            end
            if (k == 19) begin
                checkOutput("t_c19_arvalid", 512'(arvalid), 512'(0));
                checkOutput("t_c19_busy", 512'(busy), 512'(1));
            end
            if (k == 20) begin
                checkOutput("t_c20_busy", 512'(busy), 512'(0));
                checkOutput("t_c20_arvalid", 512'(arvalid), 512'(0));
            end
            if (k == 21) begin
                checkOutput("t_c21_arvalid", 512'(arvalid), 512'(1));
                checkOutput("t_c21_araddr", 512'(araddr), 512'(32'h0000_0B40));
            end
        end
        miss = 1'b0;
        checkOutput("t_refresh_cycle", 512'(ref_cyc), 512'(18));
        waitIdle("b2b", 100);
        checkOutput("b2b_refresh", 512'(refresh_cnt), 512'(2));
        checkOutput("b2b_ar_count", 512'(ar_cnt), 512'(2));

        // Flush during R beat 5: the burst still completes, the install is
        // suppressed, and the next miss installs normally.
        v = vecs[0];
        v.rbase = 32'hD000_0000;
        applyStimulus(v);
        for (int k = 0; k < 50 && r_cnt != 5; k++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("flush_beat5_reached", 512'(r_cnt), 512'(5));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        waitIdle("flush", 100);
        checkOutput("flush_refresh", 512'(refresh_cnt), 512'(0));
        checkOutput("flush_r_beats", 512'(r_cnt), 512'(16));
        v.rbase = 32'hE000_0000;
        applyStimulus(v);
        waitIdle("after_flush", 100);
        checkOutput("after_flush_refresh", 512'(refresh_cnt), 512'(1));
        checkOutput("after_flush_line", snap_line, makeLine(32'hE000_0000));

        // Reset asserted while W beat 7 is presented, then a fresh dirty miss.
        v = vecs[1];
        applyStimulus(v);
        for (int k = 0; k < 50 && w_cnt != 7; k++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("rst_beat7_reached", 512'(w_cnt), 512'(7));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkResetOutputs("midrst");
        applyStimulus(v);
        waitIdle("post_rst", 200);
        checkOutput("post_rst_aw_count", 512'(aw_cnt), 512'(1));
        checkOutput("post_rst_w_beats", 512'(w_cnt), 512'(16));
        checkOutput("post_rst_w_bad", 512'(w_bad), 512'(0));
        checkOutput("post_rst_refresh", 512'(refresh_cnt), 512'(1));
        checkOutput("post_rst_line", snap_line, makeLine(32'hB000_0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
